// File: rtl/id_decode_stage_pkg.sv
// Shared decode constants: EX ALU op encoding, RV32I opcode/funct fields,
// immediate format selector and the registered ID/EX bundle layout.
package id_decode_stage_pkg;

    // ALU operation encoding consumed by the EX stage; values must stay in step with the EX ALU.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_BEQ = 4'd11;
    localparam logic [3:0] ALU_BNE = 4'd12;
    localparam logic [3:0] ALU_BGE = 4'd13;
    localparam logic [3:0] ALU_BLT = 4'd14;

    // Major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for BRANCH.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // Immediate formats selected by the opcode.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Contents of the ID/EX register (valid is kept separately).
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        is_signed;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic [2:0]  mem_size;
    } idex_t;

    // Load widths that exist in RV32I: LB LH LW LBU LHU.
    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/id_decode_stage_imm_gen.sv
// Immediate generator: picks and sign-extends the I/S/B/U/J immediate
// out of instr[31:7] according to the requested format.
module id_decode_stage_imm_gen
    import id_decode_stage_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    // Format mux; IMM_NONE (R-type and unknown opcodes) yields zero.
    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'd0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I(+MUL) decode stage. Accepts instr/pc on if_valid&id_ready, reads the
// register file combinationally, decodes into the EX ALU encoding and registers
// the result into the ID/EX bundle. Handshake: a transfer happens on a rising
// edge where valid&ready are both high; valid never depends on ready, and a
// held bundle (ex_valid & ~ex_ready) keeps every ex_* output stable.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_op,
    output logic        ex_is_signed,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_we,
    output logic        ex_mem_re,
    output logic        ex_mem_we,
    output logic        ex_branch,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_illegal,
    output logic [2:0]  ex_mem_size
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm_val;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
    idex_t       dec;
    logic        adv;
    logic        hz;
    logic        accept;
    idex_t       ex_q;
    idex_t       ex_d;
    logic        ex_valid_q;
    logic        ex_valid_d;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign shamt    = if_instr[24:20];
    assign funct7   = if_instr[31:25];

    // Format and register usage follow the opcode alone, so a known opcode with
    // a bad funct field still counts its source registers for hazard checking.
    always_comb begin
        imm_fmt  = IMM_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_OP_IMM: begin imm_fmt = IMM_I; rs1_used = 1'b1; end
            OPC_LOAD:   begin imm_fmt = IMM_I; rs1_used = 1'b1; end
            OPC_JALR:   begin imm_fmt = IMM_I; rs1_used = 1'b1; end
            OPC_STORE:  begin imm_fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_BRANCH: begin imm_fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_LUI:    imm_fmt = IMM_U;
            OPC_AUIPC:  imm_fmt = IMM_U;
            OPC_JAL:    imm_fmt = IMM_J;
            default:    imm_fmt = IMM_NONE;
        endcase
    end

    id_decode_stage_imm_gen u_imm_gen (
        .instr_i (if_instr[31:7]),
        .fmt_i   (imm_fmt),
        .imm_o   (imm_val)
    );

    // Main decode: ALU op, operands and control flags; illegal encodings keep
    // ex_valid semantics but have all side effects squashed.
    always_comb begin
        dec         = '0;
        illegal     = 1'b0;
        dec.pc      = if_pc;
        dec.rd      = rd;
        dec.rs2_val = rs2_data;
        dec.imm     = imm_val;
        case (opcode)
            OPC_OP: begin
                dec.a      = rs1_data;
                dec.b      = rs2_data;
                dec.reg_we = 1'b1;
                if (funct7 == F7_MUL) begin
                    if (ENABLE_MUL && (funct3 == F3_ADD_SUB)) dec.alu_op = ALU_MUL;
                    else                                      illegal    = 1'b1;
                end else if ((funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)))) begin
                    case (funct3)
                        F3_ADD_SUB: dec.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                        F3_SLL:     dec.alu_op = ALU_SLL;
                        F3_SLT:     begin dec.alu_op = ALU_SLT; dec.is_signed = 1'b1; end
                        F3_SLTU:    dec.alu_op = ALU_SLT;
                        F3_XOR:     dec.alu_op = ALU_XOR;
                        F3_SR:      dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        F3_OR:      dec.alu_op = ALU_OR;
                        default:    dec.alu_op = ALU_AND;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.a      = rs1_data;
                dec.b      = imm_val;
                dec.reg_we = 1'b1;
                case (funct3)
                    F3_ADD_SUB: dec.alu_op = ALU_ADD;
                    F3_SLT:     begin dec.alu_op = ALU_SLT; dec.is_signed = 1'b1; end
                    F3_SLTU:    dec.alu_op = ALU_SLT;
                    F3_XOR:     dec.alu_op = ALU_XOR;
                    F3_OR:      dec.alu_op = ALU_OR;
                    F3_AND:     dec.alu_op = ALU_AND;
                    F3_SLL: begin
                        dec.alu_op = ALU_SLL;
                        dec.b      = {27'd0, shamt};
                        if (funct7 != F7_BASE) illegal = 1'b1;
                    end
                    default: begin
                        dec.b = {27'd0, shamt};
                        if (funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
                        else                       illegal    = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec.alu_op = ALU_LUI;
                dec.b      = imm_val;
                dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADD;
                dec.a      = if_pc;
                dec.b      = imm_val;
                dec.reg_we = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADD;
                dec.a      = if_pc;
                dec.b      = 32'd4;
                dec.reg_we = 1'b1;
                dec.jal    = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADD;
                dec.a      = if_pc;
                dec.b      = 32'd4;
                dec.reg_we = 1'b1;
                dec.jalr   = 1'b1;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op   = ALU_ADD;
                dec.a        = rs1_data;
                dec.b        = imm_val;
                dec.reg_we   = 1'b1;
                dec.mem_re   = 1'b1;
                dec.mem_size = funct3;
                if (!load_f3_legal(funct3)) illegal = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_op   = ALU_ADD;
                dec.a        = rs1_data;
                dec.b        = imm_val;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                if (funct3 > 3'b010) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.a      = rs1_data;
                dec.b      = rs2_data;
                dec.branch = 1'b1;
                case (funct3)
                    F3_BEQ:  dec.alu_op = ALU_BEQ;
                    F3_BNE:  dec.alu_op = ALU_BNE;
                    F3_BLT:  begin dec.alu_op = ALU_BLT; dec.is_signed = 1'b1; end
                    F3_BGE:  begin dec.alu_op = ALU_BGE; dec.is_signed = 1'b1; end
                    F3_BLTU: dec.alu_op = ALU_BLT;
                    F3_BGEU: dec.alu_op = ALU_BGE;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.illegal = 1'b1;
            dec.reg_we  = 1'b0;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_we = 1'b0;
    end

    // Load-use hazard: the load in ID/EX writes a register this instruction reads.
    assign hz = ex_valid_q && ex_q.mem_re && (ex_q.rd != 5'd0) &&
                ((rs1_used && (ex_q.rd == rs1_addr)) || (rs2_used && (ex_q.rd == rs2_addr)));
    assign adv      = ex_ready | ~ex_valid_q;
    assign id_ready = adv & ~hz & ~flush;
    assign accept   = if_valid & id_ready;

    // ID/EX next state: flush clears first, otherwise load on advance (a bubble when nothing is accepted).
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d = accept;
            if (accept) ex_d = dec;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_is_signed = ex_q.is_signed;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_rs2_val   = ex_q.rs2_val;
    assign ex_imm       = ex_q.imm;
    assign ex_pc        = ex_q.pc;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_we    = ex_q.reg_we;
    assign ex_mem_re    = ex_q.mem_re;
    assign ex_mem_we    = ex_q.mem_we;
    assign ex_branch    = ex_q.branch;
    assign ex_jal       = ex_q.jal;
    assign ex_jalr      = ex_q.jalr;
    assign ex_illegal   = ex_q.illegal;
    assign ex_mem_size  = ex_q.mem_size;

endmodule
